breath_envelope_gen: RTL and testbench
======================================

Name: breath_envelope_gen

Overview:
- Generates the brightness envelope for the LED breathing output: a level that ramps up, holds at full brightness, ramps down, then holds dark.
- Feeds the downstream sigma-delta PWM stage. `level` drives that stage's duty input directly.
- Replaces the free-running counter-derived triangle with a controlled sequence: programmable ramp rate, hold times at peak and trough, one-shot or continuous operation, and a graceful fade-out when disabled.

Parameters:
- LEVEL_W, 4, width of the brightness level; maximum level LMAX = 2^LEVEL_W-1.
- PRESCALE, 524288, base clock cycles per envelope step at rate_sel=0.
- PRESCALE_W, 20, prescaler counter width; must hold PRESCALE-1.
- HOLD_HI_STEPS, 8, steps held at LMAX; 0 means no hold.
- HOLD_LO_STEPS, 8, steps held at 0; 0 means no hold.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  envelope enable; low requests a fade-out to dark.
- mode  in  1  0 = continuous breathing, 1 = one-shot.
- start  in  1  one-cycle pulse; launches a one-shot cycle.
- rate_sel  in  2  step period = max(PRESCALE >> rate_sel, 1) cycles.
- level  out  LEVEL_W  current brightness, to the PWM stage.
- level_stb  out  1  one-cycle pulse in the same cycle a new level value first appears.
- phase  out  3  state code: IDLE=0, RISE=1, HOLD_HI=2, FALL=3, HOLD_LO=4.
- busy  out  1  high whenever the state is not IDLE.
- done  out  1  one-cycle pulse on the return to IDLE.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - level=0, level_stb=0, phase=IDLE, busy=0, done=0.
  - Prescaler, hold counter and abort flag cleared.
- All other logic updates on the rising edge of clk. All outputs are registered.
- Step tick:
  - The prescaler counts 0..P-1, where P is the step period.
  - tick=1 in the cycle where prescaler==P-1; the prescaler then wraps to 0.
  - The prescaler clears on every state change.
  - rate_sel is sampled into P only at state entry and at each tick. A change takes effect on the next step, never mid-step.
  - If P evaluates to 0, it is forced to 1.
- IDLE:
  - Go to RISE when en=1 and (mode=0, or mode=1 with start=1).
  - busy rises on the same edge as the transition.
  - start in any other state is ignored. start with en=0 is ignored.
- RISE:
  - On tick: level <= level+1, and level_stb pulses.
  - On the tick where level becomes LMAX: go to HOLD_HI, or to FALL if HOLD_HI_STEPS=0.
  - level never wraps past LMAX.
- HOLD_HI:
  - Count ticks; after HOLD_HI_STEPS ticks, go to FALL.
  - level is held at LMAX; no level_stb.
- FALL:
  - On tick: level <= level-1, and level_stb pulses.
  - On the tick where level becomes 0:
    - if abort is set, go to IDLE;
    - otherwise go to HOLD_LO, or go directly to the HOLD_LO exit decision if HOLD_LO_STEPS=0.
  - level never wraps below 0.
- HOLD_LO:
  - After HOLD_LO_STEPS ticks: if mode=0 and en=1, go to RISE; otherwise go to IDLE.
- Return to IDLE: done pulses for one cycle on the edge that enters IDLE, and busy falls on that same edge.
- Disable mid-operation (en=0 while busy):
  - The abort flag is set.
  - RISE or HOLD_HI exits to FALL at the next cycle boundary, without waiting for a tick. level keeps its current value.
  - FALL continues to 0, then goes to IDLE, skipping HOLD_LO.
  - HOLD_LO goes to IDLE immediately.
  - The abort flag clears on entering IDLE.
- Simultaneous events:
  - en falling on a RISE tick: the increment is applied, then the state goes to FALL.
  - A tick that reaches LMAX while en=0: the state goes to FALL, not HOLD_HI.
  - mode changes take effect only at the HOLD_LO exit decision and at IDLE.
- Downstream contract: level changes by at most ±1 per tick and stays within 0..LMAX.

Test Plan:
All scenarios use PRESCALE=4, LEVEL_W=4, HOLD_HI_STEPS=2, HOLD_LO_STEPS=2, rate_sel=0, except where stated.
1. Reset release with en=0 -> level=0, phase=0, busy=0, and no level_stb for 100 cycles. Assert rst_n low mid-RISE -> all outputs return to reset values immediately, without a clock edge.
2. Continuous mode, en=1:
   - level rises 0→15 with one level_stb every 4 cycles.
   - level is held at 15 for 8 cycles, then falls 15→0, then is held at 0 for 8 cycles.
   - Full period is 136 cycles. Exactly 30 level_stb pulses per period. done never pulses.
3. One-shot mode: start pulse -> one full cycle, then phase=0 and exactly one done pulse. A second start pulse while busy=1 -> no effect. A start pulse with en=0 -> stays in IDLE.
4. en deasserted when level=9 in RISE -> next cycle phase=3. level then steps 9→0 every 4 cycles, then IDLE, done pulses once, and no HOLD_LO is entered.
5. rate_sel changed 0→2 mid-step -> the current step still takes 4 cycles; later steps take 1 cycle (4>>2). With PRESCALE=2, rate_sel=3 -> P is forced to 1, giving one step per cycle.
6. Build with HOLD_HI_STEPS=0 and HOLD_LO_STEPS=0 -> the tick reaching 15 goes directly to FALL, the tick reaching 0 goes directly to RISE, and the period is 120 cycles.

Source files
------------

// File: rtl/breath_envelope_gen.sv
// rtl/breath_envelope_gen.sv - LED breathing envelope sequencer (rise, hold high, fall, hold low)
//
// Produces the brightness level that drives the sigma-delta PWM duty input.
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   en         envelope enable; low requests a fade-out to dark
//   mode       0 = continuous breathing, 1 = one-shot
//   start      one-cycle pulse launching a one-shot cycle from IDLE
//   rate_sel   step period = max(PRESCALE >> rate_sel, 1) clock cycles
//   level      current brightness (0..2^LEVEL_W-1)
//   level_stb  one-cycle pulse in the cycle a new level first appears
//   phase      IDLE=0, RISE=1, HOLD_HI=2, FALL=3, HOLD_LO=4
//   busy       high while not IDLE
//   done       one-cycle pulse on the return to IDLE
module breath_envelope_gen #(
    parameter int LEVEL_W       = 4,
    parameter int PRESCALE      = 524288,
    parameter int PRESCALE_W    = 20,
    parameter int HOLD_HI_STEPS = 8,
    parameter int HOLD_LO_STEPS = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               mode,
    input  logic               start,
    input  logic [1:0]         rate_sel,
    output logic [LEVEL_W-1:0] level,
    output logic               level_stb,
    output logic [2:0]         phase,
    output logic               busy,
    output logic               done
);

    localparam logic [LEVEL_W-1:0] LMAX = '1;
    localparam int HOLD_MAX = (HOLD_HI_STEPS > HOLD_LO_STEPS) ? HOLD_HI_STEPS : HOLD_LO_STEPS;
    localparam int HOLD_W   = (HOLD_MAX < 2) ? 1 : $clog2(HOLD_MAX);
    // Last count value of each hold; unused when the matching hold is 0 steps.
    localparam logic [HOLD_W-1:0] HI_LAST = HOLD_W'(HOLD_HI_STEPS - 1);
    localparam logic [HOLD_W-1:0] LO_LAST = HOLD_W'(HOLD_LO_STEPS - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RISE    = 3'd1,
        S_HOLD_HI = 3'd2,
        S_FALL    = 3'd3,
        S_HOLD_LO = 3'd4
    } state_t;

    state_t                state;
    state_t                state_n;
    logic [LEVEL_W-1:0]    level_n;
    logic                  stb_n;
    logic [PRESCALE_W-1:0] presc;
    logic [PRESCALE_W-1:0] period_m1;
    logic [HOLD_W-1:0]     hold_cnt;
    logic [HOLD_W-1:0]     hold_n;
    logic                  abort;
    logic                  tick;
    logic                  stop;
    logic                  changed;

    // Step period minus one, clamped so a zero period behaves as one cycle.
    function automatic logic [PRESCALE_W-1:0] step_period_m1(input logic [1:0] rs);
        int p;
        p = PRESCALE >> rs;
        if (p < 1) begin
            p = 1;
        end
        return PRESCALE_W'(p - 1);
    endfunction

    assign tick    = (presc == period_m1);
    // A fade-out is wanted either from a latched disable or from en low right now,
    // so the state reacts on the very edge that first sees en low.
    assign stop    = abort | ~en;
    assign changed = (state_n != state);
    assign phase   = state;

    always_comb begin
        state_n = state;
        level_n = level;
        stb_n   = 1'b0;
        hold_n  = hold_cnt;
        case (state)
            S_IDLE: begin
                if (en && (!mode || start)) begin
                    state_n = S_RISE;
                end
            end
            S_RISE: begin
                if (tick && (level != LMAX)) begin
                    level_n = level + 1'b1;
                    stb_n   = 1'b1;
                end
                // The increment on a tick still lands even when the fade-out wins.
                if (stop) begin
                    state_n = S_FALL;
                end else if (tick && (level_n == LMAX)) begin
                    state_n = (HOLD_HI_STEPS == 0) ? S_FALL : S_HOLD_HI;
                end
            end
            S_HOLD_HI: begin
                if (stop) begin
                    state_n = S_FALL;
                end else if (tick) begin
                    if (hold_cnt == HI_LAST) begin
                        state_n = S_FALL;
                    end else begin
                        hold_n = hold_cnt + 1'b1;
                    end
                end
            end
            S_FALL: begin
                if (tick) begin
                    if (level != '0) begin
                        level_n = level - 1'b1;
                        stb_n   = 1'b1;
                    end
                    if (level_n == '0) begin
                        if (stop) begin
                            state_n = S_IDLE;
                        end else if (HOLD_LO_STEPS == 0) begin
                            state_n = (!mode && en) ? S_RISE : S_IDLE;
                        end else begin
                            state_n = S_HOLD_LO;
                        end
                    end
                end
            end
            S_HOLD_LO: begin
                if (stop) begin
                    state_n = S_IDLE;
                end else if (tick) begin
                    if (hold_cnt == LO_LAST) begin
                        state_n = (!mode && en) ? S_RISE : S_IDLE;
                    end else begin
                        hold_n = hold_cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
        if (state_n != state) begin
            hold_n = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            level     <= '0;
            level_stb <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            presc     <= '0;
            period_m1 <= step_period_m1(2'd0);
            hold_cnt  <= '0;
            abort     <= 1'b0;
        end else begin
            state     <= state_n;
            level     <= level_n;
            level_stb <= stb_n;
            busy      <= (state_n != S_IDLE);
            done      <= (state != S_IDLE) && (state_n == S_IDLE);
            hold_cnt  <= hold_n;
            abort     <= (state_n == S_IDLE) ? 1'b0 : (abort | (~en & (state != S_IDLE)));
            presc     <= (changed || tick || (state == S_IDLE)) ? '0 : presc + 1'b1;
            // rate_sel is only taken at step boundaries so a step is never stretched or cut.
            if (changed || tick) begin
                period_m1 <= step_period_m1(rate_sel);
            end
        end
    end

endmodule

// File: tb/tb_breath_envelope_gen.sv
// tb/tb_breath_envelope_gen.sv - scoreboard bench for breath_envelope_gen against a step-level model
module tb_breath_envelope_gen;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       mode;
    logic       start;
    logic [1:0] rate_sel;

    logic [3:0] level_a, level_b;
    logic       stb_a, stb_b;
    logic [2:0] phase_a, phase_b;
    logic       busy_a, busy_b;
    logic       done_a, done_b;

    always #5 clk = ~clk;

    breath_envelope_gen #(
        .LEVEL_W(4), .PRESCALE(4), .PRESCALE_W(3), .HOLD_HI_STEPS(2), .HOLD_LO_STEPS(2)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .start(start), .rate_sel(rate_sel),
        .level(level_a), .level_stb(stb_a), .phase(phase_a), .busy(busy_a), .done(done_a)
    );

    breath_envelope_gen #(
        .LEVEL_W(4), .PRESCALE(4), .PRESCALE_W(3), .HOLD_HI_STEPS(0), .HOLD_LO_STEPS(0)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .start(start), .rate_sel(rate_sel),
        .level(level_b), .level_stb(stb_b), .phase(phase_b), .busy(busy_b), .done(done_b)
    );

    typedef struct {
        int cyc;
        int lvl;
        int ph;
        bit stb;
        bit dn;
        bit bsy;
    } ev_t;

    ev_t q_a[$];
    ev_t q_b[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit rel_pending = 1'b0;
    bit chk_period  = 1'b0;

    // Reference model state: phase name code, brightness, cycles left in the current
    // step, hold steps left, latched disable.
    int m_ph[2];
    int m_lv[2];
    int m_left[2];
    int m_hold[2];
    bit m_ab[2];

    int prev_ph[2];
    int last_rise[2];
    int stb_cnt[2];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int hi_of(input int id);
        return (id == 0) ? 2 : 0;
    endfunction

    function automatic int lo_of(input int id);
        return (id == 0) ? 2 : 0;
    endfunction

    function automatic int exp_per(input int id);
        return (id == 0) ? 136 : 120;
    endfunction

    function automatic int pval(input int rs);
        int p;
        p = 4 >> rs;
        return (p == 0) ? 1 : p;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_ph[i] = 0; m_lv[i] = 0; m_left[i] = 0; m_hold[i] = 0; m_ab[i] = 1'b0;
        end
        q_a.delete();
        q_b.delete();
    endtask

    // Predicts what the DUT shows after the coming rising edge, given the inputs now applied.
    task automatic step_model(input int id, input bit e, input bit md, input bit st, input int rs);
        int  ph, nx, lv;
        bit  tick, ab, stb, dn;
        ev_t ev;
        ph   = m_ph[id];
        lv   = m_lv[id];
        nx   = ph;
        stb  = 1'b0;
        tick = (ph != 0) && (m_left[id] == 1);
        ab   = m_ab[id] || !e;
        case (ph)
            0: if (e && (!md || st)) nx = 1;
            1: begin
                if (tick && lv < 15) begin lv++; stb = 1'b1; end
                if (ab) nx = 3;
                else if (tick && lv == 15) nx = (hi_of(id) > 0) ? 2 : 3;
            end
            2: begin
                if (ab) nx = 3;
                else if (tick) begin
                    m_hold[id]--;
                    if (m_hold[id] == 0) nx = 3;
                end
            end
            3: begin
                if (tick) begin
                    if (lv > 0) begin lv--; stb = 1'b1; end
                    if (lv == 0) begin
                        if (ab) nx = 0;
                        else if (lo_of(id) > 0) nx = 4;
                        else nx = (!md && e) ? 1 : 0;
                    end
                end
            end
            4: begin
                if (ab) nx = 0;
                else if (tick) begin
                    m_hold[id]--;
                    if (m_hold[id] == 0) nx = (!md && e) ? 1 : 0;
                end
            end
            default: nx = 0;
        endcase
        dn = (nx == 0) && (ph != 0);
        if (nx != ph) begin
            m_left[id] = pval(rs);
            m_hold[id] = (nx == 2) ? hi_of(id) : ((nx == 4) ? lo_of(id) : 0);
        end else if (tick) begin
            m_left[id] = pval(rs);
        end else if (ph != 0) begin
            m_left[id]--;
        end
        m_ab[id] = (nx == 0) ? 1'b0 : (m_ab[id] || (!e && ph != 0));
        m_ph[id] = nx;
        m_lv[id] = lv;
        if (stb || dn || nx != ph) begin
            ev.cyc = cyc + 1; ev.lvl = lv; ev.ph = nx; ev.stb = stb; ev.dn = dn; ev.bsy = (nx != 0);
            if (id == 0) q_a.push_back(ev);
            else q_b.push_back(ev);
        end
    endtask

    task automatic drive_cycle(input bit e, input bit md, input bit st, input int rs);
        @(negedge clk);
        if (rel_pending) begin
            rst_n = 1'b1;
            rel_pending = 1'b0;
        end
        en = e; mode = md; start = st; rate_sel = 2'(rs);
        if (rst_n) begin
            step_model(0, e, md, st, rs);
            step_model(1, e, md, st, rs);
        end
    endtask

    task automatic check_dut(input int id, input logic [3:0] lv, input logic stb,
                             input logic [2:0] ph, input logic bsy, input logic dn);
        ev_t e;
        bit  have;
        if (stb || dn || int'(ph) != prev_ph[id]) begin
            if (stb) stb_cnt[id]++;
            if (ph == 3'd1 && prev_ph[id] != 1) begin
                if (chk_period && last_rise[id] >= 0) begin
                    total++;
                    if ((cyc - last_rise[id]) != exp_per(id) || stb_cnt[id] != 30) begin
                        bad++;
                        $display("FAIL period dut%0d: got %0d cycles %0d strobes, want %0d cycles 30 strobes",
                                 id, cyc - last_rise[id], stb_cnt[id], exp_per(id));
                    end
                end
                last_rise[id] = cyc;
                stb_cnt[id]   = 0;
            end
            total++;
            have = 1'b0;
            if (id == 0 && q_a.size() > 0) begin e = q_a.pop_front(); have = 1'b1; end
            if (id == 1 && q_b.size() > 0) begin e = q_b.pop_front(); have = 1'b1; end
            if (!have) begin
                bad++;
                $display("FAIL extra_event dut%0d @%0d: got lvl=%0d ph=%0d stb=%0d done=%0d, want no event",
                         id, cyc, lv, ph, stb, dn);
            end else if (e.cyc != cyc || e.lvl != int'(lv) || e.ph != int'(ph) ||
                         e.stb != stb || e.dn != dn || e.bsy != bsy) begin
                bad++;
                $display("FAIL event dut%0d: got cyc=%0d lvl=%0d ph=%0d stb=%0d done=%0d busy=%0d, want cyc=%0d lvl=%0d ph=%0d stb=%0d done=%0d busy=%0d",
                         id, cyc, lv, ph, stb, dn, bsy, e.cyc, e.lvl, e.ph, e.stb, e.dn, e.bsy);
            end
        end
        prev_ph[id] = int'(ph);
    endtask

    // Monitor: compares whenever a DUT presents a strobe, done or phase change.
    initial begin
        prev_ph[0] = 0; prev_ph[1] = 0;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1) begin
                check_dut(0, level_a, stb_a, phase_a, busy_a, done_a);
                check_dut(1, level_b, stb_b, phase_b, busy_b, done_b);
            end else begin
                prev_ph[0] = int'(phase_a);
                prev_ph[1] = int'(phase_b);
            end
        end
    end

    task automatic check_reset_vals(input string name);
        total++;
        if ({level_a, stb_a, phase_a, busy_a, done_a} !== 10'd0) begin
            bad++;
            $display("FAIL %s dut0: got lvl=%0d stb=%0d ph=%0d busy=%0d done=%0d, want all 0",
                     name, level_a, stb_a, phase_a, busy_a, done_a);
        end
        total++;
        if ({level_b, stb_b, phase_b, busy_b, done_b} !== 10'd0) begin
            bad++;
            $display("FAIL %s dut1: got lvl=%0d stb=%0d ph=%0d busy=%0d done=%0d, want all 0",
                     name, level_b, stb_b, phase_b, busy_b, done_b);
        end
    endtask

    initial begin
        bit e, md, st;
        int rs;
        rst_n = 1'b0; en = 1'b0; mode = 1'b0; start = 1'b0; rate_sel = 2'd0;
        model_reset();
        last_rise[0] = -1; last_rise[1] = -1; stb_cnt[0] = 0; stb_cnt[1] = 0;

        repeat (3) drive_cycle(0, 0, 0, 0);
        check_reset_vals("reset");
        rel_pending = 1'b1;
        repeat (100) drive_cycle(0, 0, 0, 0);
        check_reset_vals("idle_en0");

        // Continuous breathing with period checks.
        chk_period = 1'b1;
        last_rise[0] = -1; last_rise[1] = -1;
        repeat (450) drive_cycle(1, 0, 0, 0);
        chk_period = 1'b0;

        // Disable while rising at level 9.
        for (int i = 0; i < 400 && !(m_ph[0] == 1 && m_lv[0] == 9); i++) drive_cycle(1, 0, 0, 0);
        for (int i = 0; i < 300 && (m_ph[0] != 0 || m_ph[1] != 0); i++) drive_cycle(0, 0, 0, 0);

        // One-shot, ignored restart while busy, ignored start with en low.
        repeat (5) drive_cycle(0, 1, 0, 0);
        drive_cycle(1, 1, 1, 0);
        repeat (20) drive_cycle(1, 1, 0, 0);
        drive_cycle(1, 1, 1, 0);
        repeat (150) drive_cycle(1, 1, 0, 0);
        drive_cycle(0, 1, 1, 0);
        repeat (20) drive_cycle(0, 1, 0, 0);

        // Asynchronous reset in the middle of RISE.
        for (int i = 0; i < 100 && !(m_ph[0] == 1 && m_lv[0] >= 3); i++) drive_cycle(1, 0, 0, 0);
        #2 rst_n = 1'b0;
        model_reset();
        #1 check_reset_vals("async_reset");
        drive_cycle(0, 0, 0, 0);
        rel_pending = 1'b1;
        drive_cycle(0, 0, 0, 0);

        // rate_sel change mid-step, then clamped period.
        for (int i = 0; i < 100 && !(m_ph[0] == 1 && m_left[0] == 2); i++) drive_cycle(1, 0, 0, 0);
        repeat (60) drive_cycle(1, 0, 0, 2);
        repeat (60) drive_cycle(1, 0, 0, 3);
        repeat (20) drive_cycle(1, 0, 0, 0);

        // Randomized operation.
        e = 1'b1; md = 1'b0; rs = 0;
        repeat (4000) begin
            if ($urandom_range(0, 79) == 0) e = ~e;
            if ($urandom_range(0, 149) == 0) md = ~md;
            if ($urandom_range(0, 59) == 0) rs = int'($urandom_range(0, 3));
            st = ($urandom_range(0, 19) == 0);
            drive_cycle(e, md, st, rs);
        end

        repeat (150) drive_cycle(0, 0, 0, 3);
        @(negedge clk);
        #1;
        total++;
        if (q_a.size() != 0) begin
            bad++;
            $display("FAIL pending dut0: got %0d unmatched expected events, want 0", q_a.size());
        end
        total++;
        if (q_b.size() != 0) begin
            bad++;
            $display("FAIL pending dut1: got %0d unmatched expected events, want 0", q_b.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
